// File: rtl/parity_serial_tx_if.sv
// parity_serial_tx_if: nibble/parity handshake from the parity generator into the serial transmitter.
interface parity_serial_tx_if;
   logic [3:0] din0;
   logic       even_in;
   logic       odd_in;
   logic       parity_sel;
   logic       in_valid;
   logic       in_ready;
   modport master (output din0, even_in, odd_in, parity_sel, in_valid, input in_ready);
   modport slave  (input din0, even_in, odd_in, parity_sel, in_valid, output in_ready);
endinterface

// File: rtl/parity_serial_tx.sv
// parity_serial_tx: frames a nibble as start, 4 data bits LSB first, parity, stop on one serial line.
module parity_serial_tx #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   parity_serial_tx_if.slave    i_bus,
   output logic                 o_tx_out,
   output logic                 o_busy,
   output logic                 o_done
);
   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   state_t          r_state;
   logic [BW-1:0]   r_baud;
   logic [1:0]      r_bit;
   logic [3:0]      r_data;
   logic            r_par;
   logic            w_wrap;
   assign w_wrap = r_baud == BW'(CLKS_PER_BIT - 1);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= IDLE;
         r_baud         <= '0;
         r_bit          <= '0;
         r_data         <= '0;
         r_par          <= 1'b0;
         o_tx_out       <= 1'b1;
         o_busy         <= 1'b0;
         o_done         <= 1'b0;
         i_bus.in_ready <= 1'b1;
      end else begin
         o_done <= 1'b0;
         r_baud <= (r_state == IDLE || w_wrap) ? '0 : r_baud + 1'b1;
         case (r_state)
            IDLE: if (i_bus.in_valid && i_bus.in_ready) begin
               r_data         <= i_bus.din0;
               r_par          <= i_bus.parity_sel ? i_bus.odd_in : i_bus.even_in;
               r_state        <= START;
               o_tx_out       <= 1'b0;
               o_busy         <= 1'b1;
               i_bus.in_ready <= 1'b0;
            end
            START: if (w_wrap) begin
               r_state  <= DATA;
               r_bit    <= 2'd0;
               o_tx_out <= r_data[0];
            end
            // tx_out is loaded one bit ahead so the line stays registered
            DATA: if (w_wrap) begin
               r_state  <= (r_bit == 2'd3) ? PARITY : DATA;
               r_bit    <= r_bit + 2'd1;
               o_tx_out <= (r_bit == 2'd3) ? r_par : r_data[r_bit + 2'd1];
            end
            PARITY: if (w_wrap) begin
               r_state  <= STOP;
               o_tx_out <= 1'b1;
            end
            STOP: if (w_wrap) begin
               r_state        <= IDLE;
               o_busy         <= 1'b0;
               o_done         <= 1'b1;
               i_bus.in_ready <= 1'b1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_parity_serial_tx.sv
// tb_parity_serial_tx: directed frame checks at CLKS_PER_BIT = 4 and 1.
module tb_parity_serial_tx;
   logic       clk;
   logic       rst_n;
   logic [3:0] din;
   logic       ev, od, sel, v4, v1, use1;
   logic       tx4, busy4, done4, tx1, busy1, done1;
   logic       tx_o, busy_o, done_o, rdy_o;
   int         n_vec, n_err;
   parity_serial_tx_if if4 ();
   parity_serial_tx_if if1 ();
   assign if4.din0 = din;
   assign if4.even_in = ev;
   assign if4.odd_in = od;
   assign if4.parity_sel = sel;
   assign if4.in_valid = v4;
   assign if1.din0 = din;
   assign if1.even_in = ev;
   assign if1.odd_in = od;
   assign if1.parity_sel = sel;
   assign if1.in_valid = v1;
   assign tx_o   = use1 ? tx1 : tx4;
   assign busy_o = use1 ? busy1 : busy4;
   assign done_o = use1 ? done1 : done4;
   assign rdy_o  = use1 ? if1.in_ready : if4.in_ready;
   parity_serial_tx #(.CLKS_PER_BIT(4)) dut4 (.clk(clk), .rst_n(rst_n), .i_bus(if4.slave),
      .o_tx_out(tx4), .o_busy(busy4), .o_done(done4));
   parity_serial_tx #(.CLKS_PER_BIT(1)) dut1 (.clk(clk), .rst_n(rst_n), .i_bus(if1.slave),
      .o_tx_out(tx1), .o_busy(busy1), .o_done(done1));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h at %0t", tag, obs, exp, $time);
      end
   endtask
   task automatic check_idle(input string tag, input logic done_exp);
      check({tag, "_tx"}, tx_o, 1'b1);
      check({tag, "_rdy"}, rdy_o, 1'b1);
      check({tag, "_busy"}, busy_o, 1'b0);
      check({tag, "_done"}, done_o, done_exp);
   endtask
   // Called at the negedge right after the accept edge; returns at the negedge after the done edge.
   task automatic frame(input int c, input logic [0:6] exp, input int chg_t, input string tag);
      for (int t = 0; t <= 7 * c; t++) begin
         if (t < 7 * c) begin
            check($sformatf("%s_tx%0d", tag, t), tx_o, exp[t / c]);
            check($sformatf("%s_busy%0d", tag, t), busy_o, 1'b1);
            check($sformatf("%s_done%0d", tag, t), done_o, 1'b0);
            check($sformatf("%s_rdy%0d", tag, t), rdy_o, 1'b0);
         end else
            check_idle({tag, "_end"}, 1'b1);
         if (chg_t >= 0 && t == chg_t) begin
            din = 4'b1001;
            sel = ~sel;
            v4  = 1'b1;
         end
         if (chg_t >= 0 && t == chg_t + c) v4 = 1'b0;
         if (t < 7 * c) @(negedge clk);
      end
   endtask
   task automatic load(input logic [3:0] d, input logic e, input logic o, input logic s);
      din = d;
      ev  = e;
      od  = o;
      sel = s;
   endtask
   initial begin
      n_vec = 0;
      n_err = 0;
      use1  = 1'b0;
      rst_n = 1'b0;
      v4    = 1'b0;
      v1    = 1'b0;
      load(4'b0000, 1'b0, 1'b1, 1'b0);
      repeat (3) @(negedge clk);
      check_idle("rst4", 1'b0);
      use1 = 1'b1;
      check_idle("rst1", 1'b0);
      use1  = 1'b0;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check_idle("quiet", 1'b0);
      load(4'b0011, 1'b0, 1'b1, 1'b0);
      v4 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      v4 = 1'b0;
      frame(4, 7'b0110001, -1, "even");
      @(negedge clk);
      check_idle("even_after", 1'b0);
      load(4'b0111, 1'b1, 1'b0, 1'b1);
      v4 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      v4 = 1'b0;
      frame(4, 7'b0111001, -1, "odd");
      @(negedge clk);
      load(4'b0001, 1'b1, 1'b0, 1'b0);
      v4 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      load(4'b1000, 1'b1, 1'b0, 1'b0);
      frame(4, 7'b0100011, -1, "b2b_a");
      @(negedge clk);
      v4 = 1'b0;
      frame(4, 7'b0000111, -1, "b2b_b");
      @(negedge clk);
      check_idle("b2b_after", 1'b0);
      load(4'b0011, 1'b0, 1'b1, 1'b0);
      v4 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      v4 = 1'b0;
      frame(4, 7'b0110001, 5, "mid");
      @(negedge clk);
      check_idle("mid_after", 1'b0);
      load(4'b0101, 1'b0, 1'b1, 1'b0);
      v4 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      v4 = 1'b0;
      repeat (9) @(negedge clk);
      check("rstmid_pre_tx", tx_o, 1'b0);
      rst_n = 1'b0;
      #1;
      check_idle("rstmid_async", 1'b0);
      repeat (3) begin
         @(negedge clk);
         check("rstmid_done", done_o, 1'b0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      check_idle("rstmid_rel", 1'b0);
      use1 = 1'b1;
      load(4'b0101, 1'b0, 1'b1, 1'b0);
      v1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      v1 = 1'b0;
      frame(1, 7'b0101001, -1, "c1");
      @(negedge clk);
      check_idle("c1_after", 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
